cu_mc_ctrl: RTL
===============

CU_MC_CTRL -- requirements
Module: cu_mc_ctrl

Interface
REQ-001 SHALL provide parameter MUL_CYC, default 4, total execute cycles of MUL counted from EX0 (legal range 2..16).
REQ-002 SHALL provide parameter MEM_TO, default 8, max MWT cycles before memory timeout (legal range 2..255).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ins_in  input  16  current instruction; opcode = ins_in[15:9], decoded as opcode_t from mycpu_pkg.
REQ-007 z_in  input  1  ALU zero flag.
REQ-008 n_in  input  1  ALU negative flag.
REQ-009 mem_rdy  input  1  data memory ready; completes LD/ST access in the cycle it is high.
REQ-010 resume  input  1  restart request, sampled only in HLT.
REQ-011 il_out  output  1  instruction register load.
REQ-012 ps_out  output  2  PC control: 00 hold, 01 increment, 10 relative branch, 11 jump.
REQ-013 mreq_out  output  1  data memory request.
REQ-014 wen_out  output  1  data memory write enable.
REQ-015 hlt_out  output  1  core halted.
REQ-016 err_out  output  1  sticky memory-timeout error.
REQ-017 st_out  output  3  current state, encoded as cu_state_t.

Function
REQ-018 States SHALL be RST, INF, EX0, EXM, MWT, HLT.
REQ-019 RST SHALL go to INF on the first clock edge with rst_n high.
REQ-020 INF: il_out=1, ps_out=01. Next state SHALL be EX0.
REQ-021 EX0, ALU/move/shift/LDI/ADI/IOR/IOW opcodes: ps_out=00. Next state SHALL be INF.
REQ-022 EX0, MUL: load the cycle counter with MUL_CYC-2. Next state SHALL be EXM.
REQ-023 EXM: counter decrements each cycle. At counter 0 the next state SHALL be INF, giving exactly MUL_CYC cycles from EX0 entry to INF entry.
REQ-024 EX0, LD/ST: mreq_out=1, and wen_out=1 for ST only. If mem_rdy=1, next state SHALL be INF; otherwise next state is MWT with the timeout counter cleared.
REQ-025 MWT: mreq_out and wen_out SHALL hold their EX0 values.
REQ-026 MWT: mem_rdy=1 SHALL take the FSM to INF.
REQ-027 MWT: the timeout counter increments each cycle without mem_rdy. When it reaches MEM_TO-1 with mem_rdy=0, the next state SHALL be HLT and err_out SHALL set.
REQ-028 MWT: mem_rdy=1 in the timeout cycle SHALL take priority, giving INF with no error.
REQ-029 EX0, BRZ: ps_out SHALL be 10 if z_in=1, else 00. BRN uses the same rule with n_in. Flags are sampled combinationally in EX0. Next state SHALL be INF.
REQ-030 EX0, JMP: ps_out SHALL be 11. Next state SHALL be INF.
REQ-031 EX0, HAL, XXL or any undecoded opcode: next state SHALL be HLT.
REQ-032 HLT: hlt_out=1. resume=1 with err_out=0 SHALL go to INF. With err_out=1, resume SHALL be ignored.
REQ-033 err_out SHALL clear only on reset.
REQ-034 Outputs not explicitly driven in a state SHALL be 0.
REQ-035 il_out SHALL be high only in INF. mreq_out SHALL be high only in EX0 for LD/ST and in MWT.
REQ-036 ins_in SHALL be treated as stable from EX0 through EXM/MWT. Opcode changes after EX0 SHALL not alter the path.

Reset
REQ-037 Asserting rst_n low in any state SHALL immediately force st_out=RST.
REQ-038 Reset SHALL force il_out=0, ps_out=00, mreq_out=0, wen_out=0, hlt_out=0, err_out=0, and both counters to 0.
REQ-039 Reset asserted mid-EXM or mid-MWT SHALL abort the operation with no residual counter state after release.

Verification (MUL_CYC=4, MEM_TO=8)
REQ-040 Release reset, opcode ADD -> st_out sequence RST,INF,EX0,INF. il_out=1 in each INF cycle.
REQ-041 Opcode MUL -> EX0 then EXM for 3 cycles, then INF. il_out stays low 4 cycles between loads.
REQ-042 LD with mem_rdy low 3 cycles then high -> EX0, then MWT for 3 cycles ending on the mem_rdy-high cycle, then INF. mreq_out=1 throughout EX0 and MWT, wen_out=0. ST repeated -> wen_out=1 throughout EX0 and MWT.
REQ-043 ST with mem_rdy never high -> HLT after 8 MWT cycles, err_out=1. resume pulse -> stays HLT.
REQ-044 BRZ with z_in=1 -> ps_out=10 in EX0. BRZ with z_in=0 -> ps_out=00. JMP -> ps_out=11.
REQ-045 Opcode HAL -> HLT, hlt_out=1. resume=1 -> INF next cycle. rst_n low during EXM -> RST in the same cycle with all outputs 0.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared CPU types: instruction opcodes and control-unit state encoding.
package mycpu_pkg;

   typedef enum logic [6:0] {
      OP_ADD = 7'h00,
      OP_SUB = 7'h01,
      OP_AND = 7'h02,
      OP_OR  = 7'h03,
      OP_XOR = 7'h04,
      OP_NOT = 7'h05,
      OP_MOV = 7'h06,
      OP_SHL = 7'h07,
      OP_SHR = 7'h08,
      OP_LDI = 7'h09,
      OP_ADI = 7'h0A,
      OP_IOR = 7'h0B,
      OP_IOW = 7'h0C,
      OP_MUL = 7'h10,
      OP_LD  = 7'h20,
      OP_ST  = 7'h21,
      OP_BRZ = 7'h30,
      OP_BRN = 7'h31,
      OP_JMP = 7'h32,
      OP_HAL = 7'h3E,
      OP_XXL = 7'h3F
   } opcode_t;

   typedef enum logic [2:0] {
      RST = 3'd0,
      INF = 3'd1,
      EX0 = 3'd2,
      EXM = 3'd3,
      MWT = 3'd4,
      HLT = 3'd5
   } cu_state_t;

endpackage

// File: rtl/cu_mc_ctrl.sv
// Multi-cycle CPU control unit: fetch / execute sequencing, multi-cycle MUL,
// memory wait with timeout, halt / resume.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ins_in[15:0]        instruction, opcode in [15:9]
//   z_in, n_in          ALU zero / negative flags (used in EX0 for branches)
//   mem_rdy             data memory ready
//   resume              restart request, honoured in HLT only without error
//   il_out              instruction register load
//   ps_out[1:0]         PC control: 00 hold, 01 inc, 10 rel branch, 11 jump
//   mreq_out, wen_out   data memory request / write enable
//   hlt_out, err_out    halted, sticky memory-timeout error
//   st_out[2:0]         current state (cu_state_t)
// Outputs are decoded from the state register; in EX0 they also depend on
// the opcode and flags of the same cycle.
module cu_mc_ctrl
   import mycpu_pkg::*;
#(
   parameter int unsigned MUL_CYC = 4,
   parameter int unsigned MEM_TO  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ins_in,
   input  logic        z_in,
   input  logic        n_in,
   input  logic        mem_rdy,
   input  logic        resume,
   output logic        il_out,
   output logic [1:0]  ps_out,
   output logic        mreq_out,
   output logic        wen_out,
   output logic        hlt_out,
   output logic        err_out,
   output logic [2:0]  st_out
);

   localparam int unsigned MC_W = 4;
   localparam int unsigned TO_W = 8;
   localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MUL_CYC - 2);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

   cu_state_t       state, state_nxt;
   logic [MC_W-1:0] mc_cnt, mc_nxt;
   logic [TO_W-1:0] to_cnt, to_nxt;
   logic            err_q, err_nxt;
   logic            is_st, is_st_nxt;
   opcode_t         opc;
   logic            unused_ins;

   assign opc        = opcode_t'(ins_in[15:9]);
   assign unused_ins = ^ins_in[8:0];
   assign err_out    = err_q;
   assign st_out     = state;

   // State, counters, sticky error and latched store flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RST;
         mc_cnt <= '0;
         to_cnt <= '0;
         err_q  <= 1'b0;
         is_st  <= 1'b0;
      end else begin
         state  <= state_nxt;
         mc_cnt <= mc_nxt;
         to_cnt <= to_nxt;
         err_q  <= err_nxt;
         is_st  <= is_st_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt = state;
      mc_nxt    = mc_cnt;
      to_nxt    = to_cnt;
      err_nxt   = err_q;
      is_st_nxt = is_st;
      il_out    = 1'b0;
      ps_out    = 2'b00;
      mreq_out  = 1'b0;
      wen_out   = 1'b0;
      hlt_out   = 1'b0;

      case (state)
         RST: state_nxt = INF;
         INF: begin
            il_out    = 1'b1;
            ps_out    = 2'b01;
            state_nxt = EX0;
         end
         EX0: begin
            state_nxt = INF;
            case (opc)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV,
               OP_SHL, OP_SHR, OP_LDI, OP_ADI, OP_IOR, OP_IOW:
                  ps_out = 2'b00;
               OP_MUL: begin
                  mc_nxt    = MC_LOAD;
                  state_nxt = EXM;
               end
               OP_LD, OP_ST: begin
                  mreq_out  = 1'b1;
                  wen_out   = (opc == OP_ST);
                  // Remember the access type so MWT ignores later opcode changes
                  is_st_nxt = (opc == OP_ST);
                  if (!mem_rdy) begin
                     to_nxt    = '0;
                     state_nxt = MWT;
                  end
               end
               OP_BRZ: ps_out = z_in ? 2'b10 : 2'b00;
               OP_BRN: ps_out = n_in ? 2'b10 : 2'b00;
               OP_JMP: ps_out = 2'b11;
               default: state_nxt = HLT;
            endcase
         end
         EXM: begin
            if (mc_cnt == '0) begin
               state_nxt = INF;
            end else begin
               mc_nxt = mc_cnt - 1'b1;
            end
         end
         MWT: begin
            mreq_out = 1'b1;
            wen_out  = is_st;
            // Ready wins over timeout in the same cycle
            if (mem_rdy) begin
               state_nxt = INF;
            end else if (to_cnt == TO_LAST) begin
               state_nxt = HLT;
               err_nxt   = 1'b1;
            end else begin
               to_nxt = to_cnt + 1'b1;
            end
         end
         HLT: begin
            hlt_out = 1'b1;
            if (resume && !err_q) begin
               state_nxt = INF;
            end
         end
         default: state_nxt = RST;
      endcase
   end

endmodule
